// File: rtl/image_pass_sequencer.sv
// rtl/image_pass_sequencer.sv - runs masked image passes in index order and owns the shared RAM port
module image_pass_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_STAGES-1:0]        stage_mask,
    input  logic                         pause_in,
    output logic                         pause_out,
    output logic [NUM_STAGES-1:0]        stage_enable,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES-1:0]        stage_wren,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_data_write,
    output logic                         mem_wren,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_data_write,
    output logic [2:0]                   active_stage,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_error
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SELECT, RUN, DRAIN, FINISH} state_t;

    state_t                state, state_next;
    logic [3:0]            idx;
    logic [NUM_STAGES-1:0] mask_q;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            sel_idx;
    logic                  sel_found;
    logic                  cur_done;
    logic                  timeout_hit;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = idx;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) >= idx)) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        cur_done       = 1'b0;
        stage_enable   = '0;
        mem_wren       = 1'b0;
        mem_address    = '0;
        mem_data_write = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx == 4'(i)) begin
                cur_done = stage_done[i];
                if (state == RUN) begin
                    stage_enable[i] = 1'b1;
                    mem_wren        = stage_wren[i];
                    mem_address     = stage_address[i*ADDR_W +: ADDR_W];
                    mem_data_write  = stage_data_write[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign timeout_hit  = !pause_in && (cnt == CNT_LAST);
    assign pause_out    = pause_in;
    assign busy         = (state != IDLE);
    assign done         = (state == FINISH);
    assign active_stage = idx[2:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SELECT;
            SELECT:  state_next = sel_found ? RUN : FINISH;
            RUN:     if (cur_done || timeout_hit) state_next = DRAIN;
            DRAIN:   if (!cur_done) state_next = SELECT;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            mask_q        <= '0;
            cnt           <= '0;
            timeout_error <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q        <= stage_mask;
                        timeout_error <= 1'b0;
                        idx           <= '0;
                        cnt           <= '0;
                    end
                end
                SELECT: begin
                    if (sel_found) idx <= sel_idx;
                end
                RUN: begin
                    if (!cur_done) begin
                        // Abort empties the mask so SELECT falls straight through to FINISH.
                        if (timeout_hit) begin
                            timeout_error <= 1'b1;
                            mask_q        <= '0;
                        end
                        if (!pause_in && (cnt != CNT_FULL)) cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!cur_done) begin
                        idx <= idx + 4'd1;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_image_pass_sequencer.sv
// tb/tb_image_pass_sequencer.sv - directed self-checking bench for image_pass_sequencer
module tb_image_pass_sequencer;
    localparam int NS = 4;
    localparam int AW = 18;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NS-1:0] stage_mask;
    logic          pause_in;
    logic          pause_out;
    logic [NS-1:0] stage_enable;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_wren;
    logic [NS*AW-1:0] stage_address;
    logic [NS*DW-1:0] stage_data_write;
    logic          mem_wren;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write;
    logic [2:0]    active_stage;
    logic          busy;
    logic          done;
    logic          timeout_error;

    image_pass_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stage_mask(stage_mask),
        .pause_in(pause_in), .pause_out(pause_out), .stage_enable(stage_enable),
        .stage_done(stage_done), .stage_wren(stage_wren), .stage_address(stage_address),
        .stage_data_write(stage_data_write), .mem_wren(mem_wren), .mem_address(mem_address),
        .mem_data_write(mem_data_write), .active_stage(active_stage), .busy(busy),
        .done(done), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int lat [NS];
    int scnt [NS];
    int en_cycles [NS];
    int busy_cycles, done_count, wren_cycles, bad_bus, idle_wren;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Stage model: done rises after lat enabled cycles (0 = never), drops once enable is gone.
    initial begin
        for (int i = 0; i < NS; i++) scnt[i] = 0;
        stage_done = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (stage_enable[i]) begin
                    scnt[i]++;
                    if (lat[i] != 0 && scnt[i] >= lat[i]) stage_done[i] = 1'b1;
                end else begin
                    scnt[i]       = 0;
                    stage_done[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NS; i++) en_cycles[i] += int'(stage_enable[i]);
            busy_cycles += int'(busy);
            done_count  += int'(done);
            if (mem_wren) begin
                wren_cycles++;
                if (mem_address !== exp_addr || mem_data_write !== exp_data) bad_bus++;
            end
            if (stage_enable == '0 && (mem_wren || mem_address != '0)) idle_wren++;
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < NS; i++) en_cycles[i] = 0;
        busy_cycles = 0; done_count = 0; wren_cycles = 0; bad_bus = 0; idle_wren = 0;
    endtask

    task automatic pulse_start(input logic [NS-1:0] m);
        stage_mask = m;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int limit);
        int n = 0;
        while ((busy || done_count == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < limit), 64'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stage_mask = '0; pause_in = 1'b0;
        stage_wren = '0; stage_address = '0; stage_data_write = '0;
        exp_addr = '0; exp_data = '0;
        for (int i = 0; i < NS; i++) lat[i] = 50;
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_enable", 64'(stage_enable), 64'd0);
        check("rst_terr", 64'(timeout_error), 64'd0);
        check("rst_active", 64'(active_stage), 64'd0);
        check("rst_memwren", 64'(mem_wren), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Mask 0101, 50-cycle stages.
        clear_counts();
        pulse_start(4'b0101);
        check("t1_select_busy", 64'(busy), 64'd1);
        check("t1_select_en", 64'(stage_enable), 64'd0);
        @(negedge clk);
        check("t1_run_en", 64'(stage_enable), 64'b0001);
        check("t1_run_active", 64'(active_stage), 64'd0);
        wait_end("t1_end", 500);
        @(negedge clk);
        check("t1_en0", 64'(en_cycles[0]), 64'd50);
        check("t1_en1", 64'(en_cycles[1]), 64'd0);
        check("t1_en2", 64'(en_cycles[2]), 64'd50);
        check("t1_en3", 64'(en_cycles[3]), 64'd0);
        check("t1_busy_cycles", 64'(busy_cycles), 64'd106);
        check("t1_done_count", 64'(done_count), 64'd1);
        check("t1_terr", 64'(timeout_error), 64'd0);

        // Mask 0: SELECT then FINISH.
        clear_counts();
        pulse_start(4'b0000);
        wait_end("t2_end", 20);
        repeat (2) @(negedge clk);
        check("t2_busy_cycles", 64'(busy_cycles), 64'd2);
        check("t2_done_count", 64'(done_count), 64'd1);
        check("t2_no_enable", 64'(en_cycles[0] + en_cycles[1] + en_cycles[2] + en_cycles[3]), 64'd0);

        // Bus mux: stages 0 and 1 both write, only stage 1 is selected.
        lat[1] = 20;
        stage_wren = 4'b0011;
        stage_address[0*AW +: AW] = 18'd5;
        stage_data_write[0*DW +: DW] = 32'hdead_beef;
        stage_address[1*AW +: AW] = 18'd2240;
        stage_data_write[1*DW +: DW] = 32'd1;
        exp_addr = 18'd2240; exp_data = 32'd1;
        @(negedge clk);
        clear_counts();
        pulse_start(4'b0010);
        @(negedge clk);
        check("t3_addr", 64'(mem_address), 64'd2240);
        check("t3_data", 64'(mem_data_write), 64'd1);
        wait_end("t3_end", 200);
        @(negedge clk);
        check("t3_wren_cycles", 64'(wren_cycles), 64'd20);
        check("t3_bad_bus", 64'(bad_bus), 64'd0);
        check("t3_idle_wren", 64'(idle_wren), 64'd0);
        stage_wren = '0;
        stage_address = '0;
        stage_data_write = '0;

        // Timeout: stage 0 never finishes, 30 paused cycles mid-run.
        lat[0] = 0;
        clear_counts();
        pulse_start(4'b0111);
        @(negedge clk);
        repeat (40) @(negedge clk);
        pause_in = 1'b1;
        @(negedge clk);
        check("t4_pause_out_hi", 64'(pause_out), 64'd1);
        repeat (29) @(negedge clk);
        pause_in = 1'b0;
        @(negedge clk);
        check("t4_pause_out_lo", 64'(pause_out), 64'd0);
        wait_end("t4_end", 300);
        @(negedge clk);
        check("t4_en0", 64'(en_cycles[0]), 64'd130);
        check("t4_skipped", 64'(en_cycles[1] + en_cycles[2]), 64'd0);
        check("t4_terr", 64'(timeout_error), 64'd1);
        check("t4_done_count", 64'(done_count), 64'd1);
        pulse_start(4'b0000);
        check("t4_terr_cleared", 64'(timeout_error), 64'd0);
        repeat (3) @(negedge clk);

        // Reset mid-run of stage 2; start while busy is ignored.
        lat[2] = 0;
        stage_wren = 4'b0100;
        exp_addr = '0; exp_data = '0;
        pulse_start(4'b0100);
        repeat (5) @(negedge clk);
        pulse_start(4'b0001);
        @(negedge clk);
        check("t5_no_restart_en", 64'(stage_enable), 64'b0100);
        check("t5_no_restart_idx", 64'(active_stage), 64'd2);
        check("t5_run_wren", 64'(mem_wren), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_en", 64'(stage_enable), 64'd0);
        check("t5_rst_wren", 64'(mem_wren), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_active", 64'(active_stage), 64'd0);
        reset = 1'b0;
        stage_wren = '0;
        repeat (2) @(negedge clk);
        check("t5_stays_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/image_pass_sequencer.md
# image_pass_sequencer

Sequences the single-port image RAM between up to NUM_STAGES image-processing passes (x pixel filling, y pixel filling, edge passes and similar), each of which uses the enable/done handshake and drives its own wren/address/data_write. It runs the stages selected by a mask in ascending index order, muxes the active stage's memory bus onto the shared RAM port, forwards pause, and reports completion or timeout to the top-level control FSM.

## Interface
- NUM_STAGES, 4, number of attached passes (1..8)
- ADDR_W, 18, RAM address width
- DATA_W, 32, RAM data width
- TIMEOUT_CYCLES, 1000000, max unpaused cycles a stage may run before abort
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a sequence; sampled only in IDLE
- stage_mask  in  NUM_STAGES  stages to run; latched on accepted start
- pause_in  in  1  global pause
- pause_out  out  1  equals pause_in (combinational), to all stages
- stage_enable  out  NUM_STAGES  one-hot-or-zero enable to each stage
- stage_done  in  NUM_STAGES  done from each stage
- stage_wren  in  NUM_STAGES  per-stage write enable
- stage_address  in  NUM_STAGES*ADDR_W  stage i at bits [i*ADDR_W +: ADDR_W]
- stage_data_write  in  NUM_STAGES*DATA_W  stage i at bits [i*DATA_W +: DATA_W]
- mem_wren  out  1  to RAM
- mem_address  out  ADDR_W  to RAM
- mem_data_write  out  DATA_W  to RAM
- active_stage  out  3  index of selected stage
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- timeout_error  out  1  sticky; set on abort, cleared on next accepted start

## Operation
- States: IDLE, SELECT, RUN, DRAIN, FINISH.
- IDLE: busy=0. start=1 latches stage_mask into mask_q, clears timeout_error, sets idx=0, goes SELECT. start while busy is ignored.
- SELECT: if mask_q has a set bit at index >= idx, idx := lowest such index, go RUN; else go FINISH. Mask 0 goes straight to FINISH (done still pulses).
- RUN: stage_enable[idx]=1, all others 0. Timeout counter increments each cycle with pause_in=0, holds while pause_in=1, saturates. stage_done[idx]=1 -> DRAIN. Counter reaching TIMEOUT_CYCLES (before done) -> set timeout_error, go DRAIN with mask_q cleared (abort).
- DRAIN: all enables 0 (stage clears its done and holdoff); wait until stage_done[idx]=0, then idx := idx+1, clear counter, go SELECT. Drain is not timed.
- FINISH: done=1 for exactly one cycle, go IDLE.
- Memory mux: when state is RUN, mem_* = stage idx's bus (combinational from registered idx); otherwise mem_wren=0, mem_address=0, mem_data_write=0. Stages not selected never reach the RAM.
- pause_in does not stall state transitions other than the timeout count; stages freeze themselves.
- Reset (any time, including mid-RUN): state IDLE, all stage_enable=0, idx=0, mask_q=0, counter=0, busy=0, done=0, timeout_error=0, active_stage=0.

## Timing
- start high at edge k -> SELECT after k, RUN and stage_enable high after k+1.
- stage_done[idx] sampled high at edge m -> enable low after m; mem_wren forced 0 from that cycle.
- Each DRAIN lasts >=1 cycle; SELECT always 1 cycle between stages.
- done pulse asserted the cycle after the final DRAIN's SELECT; busy falls with done's falling edge (busy=1 during FINISH).
- Timeout: abort on the edge where unpaused count equals TIMEOUT_CYCLES.

## Test plan
- Mask 4'b0101, stage models assert done 50 cycles after enable -> stage 0 enabled, then stage 2; stages 1,3 never enabled; one done pulse; timeout_error=0.
- Mask 0 with start -> busy for 2 cycles (SELECT, FINISH), done pulses once, no enable ever high.
- Stage 1 drives wren=1, address=2240, data=1 while running; stage 0 drives wren=1 simultaneously -> RAM sees only stage 1 values; mem_wren=0 during DRAIN/SELECT.
- TIMEOUT_CYCLES=100, stage never done, pause_in high 30 cycles mid-run -> abort after 130 cycles in RUN, timeout_error=1, later stages skipped, done pulses; next start clears error.
- Reset asserted mid-RUN of stage 2 -> next cycle all enables 0, mem_wren 0, busy 0; start during busy ignored (no restart, mask unchanged).
